tensor_core_kloop_ctrl: RTL and testbench
=========================================

# tensor_core_kloop_ctrl

Sequencer that runs one 4x4 FP16 `tensor_core_gemm` datapath over the K dimension. It computes C = C_init + Σ A_k·B_k for k = 0..k_tiles-1. It latches an initial C tile, accepts a stream of A/B tile pairs over a valid/ready handshake, and feeds each GEMM result back as the next C operand through an accumulator register. It then presents the final 4x4 result on a valid/ready output port. It sits between the tile fetch logic and the result write-back path.

## Interface
- `DWIDTH`, 16, element width (FP16)
- `KT_W`, 4, width of tile count/index; max k_tiles = 2^KT_W-1
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset, sampled on rising clk
- `start`  in  1  begin a job; sampled only in IDLE
- `k_tiles`  in  KT_W  number of A/B tile pairs for this job; sampled with start
- `C_init`  in  [0:3][0:3][DWIDTH-1:0]  initial accumulator; sampled with start
- `abort`  in  1  cancel current job
- `A_tile`  in  [0:3][0:3][DWIDTH-1:0]  A operand tile
- `B_tile`  in  [0:3][0:3][DWIDTH-1:0]  B operand tile
- `tile_valid`  in  1  A_tile/B_tile valid
- `tile_ready`  out  1  controller accepts tile
- `tile_idx`  out  KT_W  tiles accepted so far in this job (next k to fetch)
- `C_out`  out  [0:3][0:3][DWIDTH-1:0]  final result
- `out_valid`  out  1  C_out valid
- `out_ready`  in  1  downstream accepts C_out
- `busy`  out  1  high in any state except IDLE

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- State machine states:
  - IDLE: tile_ready=0, out_valid=0, busy=0.
  - ACCUM: tile_ready=1.
  - DONE: out_valid=1, tile_ready=0.
- IDLE → ACCUM: start=1 and k_tiles≠0. Then acc←C_init, kt_q←k_tiles, tile_idx←0.
- IDLE → DONE: start=1 and k_tiles=0. Then acc←C_init, so C_out = C_init unchanged.
- ACCUM, tile handshake (tile_valid & tile_ready):
  - acc←gemm(A_tile, B_tile, acc).
  - tile_idx←tile_idx+1.
  - If tile_idx+1 = kt_q, → DONE.
- ACCUM with tile_valid=0: hold all state.
- DONE: C_out = acc, held stable while out_valid & !out_ready. On out_ready → IDLE; acc is retained.
- GEMM operands:
  - gemm A/B are driven combinationally from A_tile/B_tile.
  - gemm C is driven from acc.
  - The GEMM result is registered only on a handshake.
- abort=1 in any state → IDLE next edge. No out_valid is generated. acc is not cleared. abort has priority over start, tile handshake and out_ready.
- start in ACCUM/DONE is ignored. k_tiles and C_init are don't-care outside IDLE.
- Arithmetic:
  - All FP behaviour (rounding, NaN/Inf) is inherited from `tensor_core_gemm`. The controller does no arithmetic.
  - tile_idx compares against the latched kt_q, never the live k_tiles.

## Timing
- Reset values: state=IDLE, tile_ready=0, out_valid=0, busy=0, tile_idx=0, C_out/acc=0.
- Reset asserted mid-job behaves as abort. Reset has priority over abort.
- Latency:
  - start at edge 0 → tile_ready high from cycle 1.
  - With tile_valid held high, tiles are accepted at edges 1..K.
  - out_valid is high from cycle K+1.
  - k_tiles=0 gives out_valid in cycle 1.
- Throughput: one tile per cycle. One job in flight.
- Back-to-back jobs: the earliest next start is sampled in the cycle after the out_ready handshake (IDLE). No start-in-DONE overlap.
- Handshakes:
  - tile_ready does not depend combinationally on tile_valid.
  - out_valid does not depend on out_ready.
- Boundary: k_tiles = 2^KT_W-1 → tile_idx reaches the max value with no wrap. tile_idx is reset to 0 only on start.

## Structure
- Shared package `tensor_core_pkg`:
  - `kloop_state_t` enum: IDLE=2'b00, ACCUM=2'b01, DONE=2'b10.
  - `mat4_t` packed type [0:3][0:3][DWIDTH-1:0].
  - FP16 constants FP16_ZERO=16'h0000, FP16_ONE=16'h3C00.
- Single sub-module: the existing combinational `tensor_core_gemm`, instantiated once as `u_tensor_core_gemm`.
- Registers: state, acc, kt_q, tile_idx.

## Test plan
- Basic accumulate: C_init=0, k_tiles=2, each tile A=identity (diag 16'h3C00), B=all 16'h3C00, tile_valid always high. Required: tiles accepted on 2 consecutive cycles; out_valid in cycle 3; C_out all 16'h4000.
- Zero-K passthrough: k_tiles=0, C_init all 16'h4200. Required: out_valid in cycle 1; C_out all 16'h4200; tile_ready never asserted.
- Stalls and backpressure: k_tiles=3, tile_valid toggling 1/0, out_ready held low 5 cycles. Required: exactly 3 handshakes; tile_idx 0→1→2→3; C_out stable while stalled; C_out all 16'h4200 with C_init=0 and the identity/ones tiles.
- Abort mid-job: k_tiles=4, assert abort after 2 tiles. Required: IDLE next cycle; busy=0; out_valid never asserted. A new start with k_tiles=1 and C_init=0 then yields all 16'h3C00.
- Reset mid-job: drop rst_n during ACCUM for one edge. Required: all outputs at reset values after that edge; start during the reset cycle is ignored.
- Max count / ignored start: k_tiles=4'hF with start pulsed again during ACCUM. Required: exactly 15 handshakes; tile_idx ends at 4'hF with no wrap; the second start has no effect.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared types and FP16 helpers for the tensor-core K-loop datapath.
// The FP16 arithmetic flushes subnormals to zero and rounds to nearest-even.
package tensor_core_pkg;

    localparam int unsigned FP_W = 16;

    localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP_W-1:0] FP16_ONE  = 16'h3C00;
    localparam logic [FP_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } kloop_state_t;

    typedef logic [0:3][0:3][FP_W-1:0] mat4_t;

    function automatic logic fp16_is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1f) && (v[9:0] != 10'h0);
    endfunction

    // Rounds a normalised 10-bit fraction and packs it; e is the biased exponent.
    function automatic logic [15:0] fp16_pack(input logic s, input int e, input logic [9:0] f,
                                              input logic g, input logic st);
        logic [10:0] r;
        int          ex;
        ex = e;
        r  = {1'b0, f} + {10'b0, g & (st | f[0])};
        if (r[10]) ex++;
        if (ex >= 31) return {s, 5'h1f, 10'h0};
        if (ex <= 0)  return {s, 15'h0};
        return {s, ex[4:0], r[9:0]};
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        logic [9:0]  f;
        logic        g;
        logic        st;
        int          e;
        s = a[15] ^ b[15];
        if (fp16_is_nan(a) || fp16_is_nan(b)) return FP16_QNAN;
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f)
            return (a[14:10] == 5'h00 || b[14:10] == 5'h00) ? FP16_QNAN : {s, 5'h1f, 10'h0};
        if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0};
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            f = p[20:11]; g = p[10]; st = |p[9:0]; e++;
        end else begin
            f = p[19:10]; g = p[9];  st = |p[8:0];
        end
        return fp16_pack(s, e, f, g, st);
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [14:0] mx;
        logic [14:0] my;
        logic [14:0] r;
        int unsigned d;
        int          e;
        if (fp16_is_nan(a) || fp16_is_nan(b)) return FP16_QNAN;
        if (a[14:10] == 5'h1f && b[14:10] == 5'h1f) return (a[15] == b[15]) ? a : FP16_QNAN;
        if (a[14:10] == 5'h1f) return a;
        if (b[14:10] == 5'h1f) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        if (x[14:10] == 5'h00) return {a[15] & b[15], 15'h0};
        if (y[14:10] == 5'h00) return x;
        d  = 32'(x[14:10]) - 32'(y[14:10]);
        e  = int'(x[14:10]);
        mx = {2'b01, x[9:0], 3'b000};
        my = {2'b01, y[9:0], 3'b000};
        // Alignment shift jams shifted-out bits into the sticky LSB.
        for (int unsigned i = 0; i < 15; i++)
            if (i < d) my = {1'b0, my[14:2], my[1] | my[0]};
        if (x[15] == y[15]) begin
            r = mx + my;
            if (r[14]) begin
                r = {1'b0, r[14:2], r[1] | r[0]};
                e++;
            end
        end else begin
            r = mx - my;
            if (r == '0) return FP16_ZERO;
            for (int unsigned i = 0; i < 13; i++)
                if (!r[13]) begin
                    r = {r[13:0], 1'b0};
                    e--;
                end
        end
        return fp16_pack(x[15], e, r[12:3], r[2], r[1] | r[0]);
    endfunction

endpackage

// File: rtl/tensor_core_gemm.sv
// Combinational 4x4 FP16 GEMM: d = c + a*b, each dot product accumulated k = 0..3 in order.
module tensor_core_gemm
    import tensor_core_pkg::*;
(
    input  mat4_t a,
    input  mat4_t b,
    input  mat4_t c,
    output mat4_t d
);

    always_comb begin
        d = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                logic [FP_W-1:0] sum;
                sum = c[i][j];
                for (int unsigned k = 0; k < 4; k++)
                    sum = fp16_add(sum, fp16_mul(a[i][k], b[k][j]));
                d[i][j] = sum;
            end
        end
    end

endmodule

// File: rtl/tensor_core_kloop_ctrl.sv
// Runs one tensor_core_gemm over K tiles, feeding each result back as the next C operand.
module tensor_core_kloop_ctrl
    import tensor_core_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned KT_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [KT_W-1:0]                k_tiles,
    input  logic [0:3][0:3][DWIDTH-1:0]    C_init,
    input  logic                           abort,
    input  logic [0:3][0:3][DWIDTH-1:0]    A_tile,
    input  logic [0:3][0:3][DWIDTH-1:0]    B_tile,
    input  logic                           tile_valid,
    output logic                           tile_ready,
    output logic [KT_W-1:0]                tile_idx,
    output logic [0:3][0:3][DWIDTH-1:0]    C_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy
);

    kloop_state_t                 state_q;
    kloop_state_t                 state_d;
    logic [0:3][0:3][DWIDTH-1:0]  acc;
    logic [0:3][0:3][DWIDTH-1:0]  gemm_d;
    logic [KT_W-1:0]              kt_q;
    logic                         last_tile;

    tensor_core_gemm u_tensor_core_gemm (
        .a (A_tile),
        .b (B_tile),
        .c (acc),
        .d (gemm_d)
    );

    assign last_tile = (tile_idx + KT_W'(1)) == kt_q;
    assign C_out     = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (k_tiles == '0) ? DONE : ACCUM;
            ACCUM:   if (tile_valid && last_tile) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        tile_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            IDLE:    busy       = 1'b0;
            ACCUM:   tile_ready = 1'b1;
            DONE:    out_valid  = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    // acc survives abort and job completion; only start or reset reloads it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            kt_q     <= '0;
            tile_idx <= '0;
        end else if (!abort) begin
            if (state_q == IDLE && start) begin
                acc      <= C_init;
                kt_q     <= k_tiles;
                tile_idx <= '0;
            end else if (state_q == ACCUM && tile_valid) begin
                acc      <= gemm_d;
                tile_idx <= tile_idx + KT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tensor_core_kloop_ctrl.sv
// Scoreboard bench for tensor_core_kloop_ctrl: directed jobs push expected C_out, a monitor pops on handshake.
module tb_tensor_core_kloop_ctrl;
    import tensor_core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  k_tiles;
    mat4_t       C_init;
    logic        abort;
    mat4_t       A_tile;
    mat4_t       B_tile;
    logic        tile_valid;
    logic        tile_ready;
    logic [3:0]  tile_idx;
    mat4_t       C_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int    n_cmp;
    int    n_err;
    int    hs_count;
    logic  tr_seen;
    logic  ov_seen;
    logic  hold_q;
    mat4_t held;
    mat4_t exp_q[$];
    int    cyc;

    tensor_core_kloop_ctrl #(.DWIDTH(16), .KT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_tiles    (k_tiles),
        .C_init     (C_init),
        .abort      (abort),
        .A_tile     (A_tile),
        .B_tile     (B_tile),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_idx   (tile_idx),
        .C_out      (C_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic mat4_t fill(input logic [15:0] v);
        mat4_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = v;
        return m;
    endfunction

    function automatic mat4_t identity();
        mat4_t m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = 16'h3C00;
        return m;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input logic [3:0] k, input mat4_t ci);
        hs_count = 0;
        tr_seen  = 1'b0;
        ov_seen  = 1'b0;
        k_tiles  = k;
        C_init   = ci;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Returns the cycle (counted from the start edge) in which out_valid is first seen.
    task automatic wait_out(input int from, input int limit, output int c);
        c = from;
        while (!out_valid && c < limit) begin
            tick();
            c++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tile_ready) tr_seen = 1'b1;
            if (out_valid)  ov_seen = 1'b1;
            if (tile_valid && tile_ready && !abort) begin
                chk("tile_idx_at_handshake", tile_idx, hs_count);
                hs_count++;
            end
            if (hold_q) chk("C_out_stable", C_out, held);
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got C_out=%0h with empty scoreboard, required no output", C_out);
                end else begin
                    chk("C_out", C_out, exp_q.pop_front());
                end
            end
            hold_q = out_valid && !out_ready && !abort;
            held   = C_out;
        end else begin
            hold_q = 1'b0;
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; hs_count = 0;
        tr_seen = 1'b0; ov_seen = 1'b0; hold_q = 1'b0; held = '0;
        rst_n = 1'b0; start = 1'b0; k_tiles = '0; C_init = '0; abort = 1'b0;
        A_tile = identity(); B_tile = fill(16'h3C00);
        tile_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_tile_ready", tile_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tile_idx", tile_idx, 0);
        chk("rst_C_out", C_out, 0);
        rst_n = 1'b1;
        tick();

        // Basic accumulate: 0 + 1 + 1 = 2.0
        tile_valid = 1'b1;
        exp_q.push_back(fill(16'h4000));
        begin_job(4'd2, fill(16'h0000));
        chk("basic_tile_ready_c1", tile_ready, 1);
        chk("basic_busy_c1", busy, 1);
        wait_out(1, 40, cyc);
        chk("basic_out_latency", cyc, 3);
        chk("basic_handshakes", hs_count, 2);
        tick();
        chk("basic_idle_after", busy, 0);

        // Zero-K passthrough
        tile_valid = 1'b0;
        exp_q.push_back(fill(16'h4200));
        begin_job(4'd0, fill(16'h4200));
        wait_out(1, 40, cyc);
        chk("zerok_out_latency", cyc, 1);
        tick();
        chk("zerok_tile_ready_never", tr_seen, 0);

        // Stalls and backpressure: 0 + 1 + 1 + 1 = 3.0
        out_ready = 1'b0;
        exp_q.push_back(fill(16'h4200));
        begin_job(4'd3, fill(16'h0000));
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            tile_valid = ~tile_valid;
            tick();
            cyc++;
        end
        tile_valid = 1'b0;
        chk("stall_out_latency", cyc, 6);
        chk("stall_handshakes", hs_count, 3);
        chk("stall_tile_idx_final", tile_idx, 3);
        repeat (5) tick();
        chk("stall_out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("stall_idle_after", busy, 0);
        chk("stall_out_valid_drop", out_valid, 0);

        // Abort after two tiles
        tile_valid = 1'b1;
        begin_job(4'd4, fill(16'h0000));
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tile_ready", tile_ready, 0);
        chk("abort_handshakes", hs_count, 2);
        chk("abort_tile_idx_held", tile_idx, 2);
        repeat (4) tick();
        chk("abort_no_out_valid", ov_seen, 0);
        exp_q.push_back(fill(16'h3C00));
        begin_job(4'd1, fill(16'h0000));
        wait_out(1, 40, cyc);
        chk("abort_restart_latency", cyc, 2);
        tick();

        // Reset mid-job, with start asserted during the reset cycle
        begin_job(4'd4, fill(16'h0000));
        tick();
        rst_n = 1'b0; start = 1'b1; k_tiles = 4'd1; C_init = fill(16'h4200);
        tick();
        chk("rstmid_tile_ready", tile_ready, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_tile_idx", tile_idx, 0);
        chk("rstmid_C_out", C_out, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk("rstmid_start_ignored", busy, 0);

        // Max count with a second start during ACCUM: 15.0
        exp_q.push_back(fill(16'h4B80));
        begin_job(4'hF, fill(16'h0000));
        tick(); tick();
        start = 1'b1; k_tiles = 4'd2; C_init = fill(16'h4200);
        tick();
        start = 1'b0;
        wait_out(4, 60, cyc);
        chk("max_out_latency", cyc, 16);
        chk("max_handshakes", hs_count, 15);
        chk("max_tile_idx", tile_idx, 15);
        tick();
        chk("max_tile_idx_no_wrap", tile_idx, 15);
        chk("max_idle_after", busy, 0);

        tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
